// File: rtl/grid_removal_sequencer_pkg.sv
// Shared types and defaults for the grid removal sequencer.
package grid_removal_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SCAN  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int THRESH_DEFAULT = 4;

endpackage

// File: rtl/grid_removal_sequencer_neighbor_count.sv
// Combinational 8-neighbour occupancy count for cell (r,c) of the grid.
module grid_neighbor_count
  import grid_removal_sequencer_pkg::*;
#(
  parameter  int WIDTH = 10,
  parameter  int DEPTH = 10,
  localparam int RW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] grid,
  input  logic [RW-1:0]               r,
  input  logic [CW-1:0]               c,
  output logic [3:0]                  count
);

  logic [DEPTH-1:0]             row_near, row_eq;
  logic [WIDTH-1:0]             col_near, col_eq;
  logic [DEPTH-1:0][WIDTH-1:0]  hit;

  // Out-of-grid neighbours simply have no row/column to match against.
  for (genvar i = 0; i < DEPTH; i++) begin : g_row
    logic up, dn;
    if (i > 0) begin : g_up
      assign up = (r == RW'(i - 1));
    end else begin : g_no_up
      assign up = 1'b0;
    end
    if (i < DEPTH - 1) begin : g_dn
      assign dn = (r == RW'(i + 1));
    end else begin : g_no_dn
      assign dn = 1'b0;
    end
    assign row_eq[i]   = (r == RW'(i));
    assign row_near[i] = row_eq[i] | up | dn;
  end

  for (genvar j = 0; j < WIDTH; j++) begin : g_col
    logic lf, rt;
    if (j > 0) begin : g_lf
      assign lf = (c == CW'(j - 1));
    end else begin : g_no_lf
      assign lf = 1'b0;
    end
    if (j < WIDTH - 1) begin : g_rt
      assign rt = (c == CW'(j + 1));
    end else begin : g_no_rt
      assign rt = 1'b0;
    end
    assign col_eq[j]   = (c == CW'(j));
    assign col_near[j] = col_eq[j] | lf | rt;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_hit_r
    for (genvar j = 0; j < WIDTH; j++) begin : g_hit_c
      assign hit[i][j] = grid[i][j] & row_near[i] & col_near[j] & ~(row_eq[i] & col_eq[j]);
    end
  end

  assign count = 4'($countones(hit));

endmodule

// File: rtl/grid_removal_sequencer.sv
// Loads a DEPTH x WIDTH occupancy grid, then sweeps it removing sparse cells until stable.
// Optional build macro GRID_ROUND_LIMIT_EN adds MAX_ROUNDS and the limit_hit output.
//
// state | meaning
// IDLE  | waiting for start after reset
// LOAD  | accepting rows 0..DEPTH-1
// SCAN  | visiting one cell per cycle, row-major, clearing in place
// CHECK | end of sweep: count round, accumulate, decide stop or resweep
// DONE  | results held until the next start
module grid_removal_sequencer
  import grid_removal_sequencer_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int DEPTH  = 10,
  parameter int THRESH = THRESH_DEFAULT,
  parameter int CNT_W  = 16
`ifdef GRID_ROUND_LIMIT_EN
  ,parameter int MAX_ROUNDS = 255
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             row_valid,
  input  logic [WIDTH-1:0] row_data,
  output logic             row_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] total_removed,
  output logic [CNT_W-1:0] round_count
`ifdef GRID_ROUND_LIMIT_EN
  ,output logic            limit_hit
`endif
);

  localparam int RW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = $clog2(WIDTH * DEPTH + 1);
  localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                      state, state_n;
  logic [DEPTH-1:0][WIDTH-1:0] grid;
  logic [RW-1:0]               row;
  logic [CW-1:0]               col;
  logic [PW-1:0]               round_cnt;
  logic [3:0]                  nbr_cnt;
  logic                        job_start, row_xfer, last_row, last_col, remove, stop_limit;
  logic [CNT_W-1:0]            round_count_n, total_n;
  logic [SW-1:0]               sum_w;

  grid_neighbor_count #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_nbr (
    .grid  (grid),
    .r     (row),
    .c     (col),
    .count (nbr_cnt)
  );

  always_comb begin
    job_start     = ((state == IDLE) || (state == DONE)) && start;
    row_xfer      = (state == LOAD) && row_valid;
    last_row      = (row == RW'(DEPTH - 1));
    last_col      = (col == CW'(WIDTH - 1));
    remove        = (state == SCAN) && grid[row][col] && (int'(nbr_cnt) < THRESH);
    round_count_n = (round_count == CNT_MAX) ? round_count : round_count + CNT_W'(1);
    sum_w         = SW'(total_removed) + SW'(round_cnt);
    total_n       = (sum_w > SW'(CNT_MAX)) ? CNT_MAX : sum_w[CNT_W-1:0];
`ifdef GRID_ROUND_LIMIT_EN
    stop_limit    = (state == CHECK) && (round_cnt != '0) && (int'(round_count_n) == MAX_ROUNDS);
`else
    stop_limit    = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    row_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_n = LOAD;
      end
      LOAD: begin
        row_ready = 1'b1;
        busy      = 1'b1;
        if (row_valid && last_row) state_n = SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        if (last_row && last_col) state_n = CHECK;
      end
      CHECK: begin
        busy    = 1'b1;
        state_n = ((round_cnt == '0) || stop_limit) ? DONE : SCAN;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_n = LOAD;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || job_start) begin
      grid          <= '0;
      row           <= '0;
      col           <= '0;
      round_cnt     <= '0;
      total_removed <= '0;
      round_count   <= '0;
`ifdef GRID_ROUND_LIMIT_EN
      limit_hit     <= 1'b0;
`endif
    end else begin
      if (row_xfer) begin
        grid[row] <= row_data;
        row       <= last_row ? '0 : row + RW'(1);
      end
      if (state == SCAN) begin
        // Clearing here is visible to every later cell of the same sweep.
        if (remove) begin
          grid[row][col] <= 1'b0;
          round_cnt      <= round_cnt + PW'(1);
        end
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      if (state == CHECK) begin
        round_count <= round_count_n;
        if (round_cnt != '0) begin
          total_removed <= total_n;
          round_cnt     <= '0;
        end
`ifdef GRID_ROUND_LIMIT_EN
        if (stop_limit) limit_hit <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_grid_removal_sequencer.sv
// Self-checking bench: randomized grids checked against a plain array model of the removal rules.
module tb_grid_removal_sequencer;

  localparam int TH = 4;
  typedef bit grid_t [16][16];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_start, a_row_valid;
  logic [9:0]  a_row_data;
  logic        a_row_ready, a_busy, a_done;
  logic [15:0] a_total, a_rounds;
  logic        c_row_ready, c_busy, c_done;
  logic [1:0]  c_total, c_rounds;
  logic        b_start, b_row_valid;
  logic [2:0]  b_row_data;
  logic        b_row_ready, b_busy, b_done;
  logic [15:0] b_total, b_rounds;
`ifdef GRID_ROUND_LIMIT_EN
  logic        a_limit, c_limit, b_limit, l_limit;
  logic        l_row_ready, l_busy, l_done;
  logic [15:0] l_total, l_rounds;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  grid_removal_sequencer #(.WIDTH(10), .DEPTH(10)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .row_valid(a_row_valid), .row_data(a_row_data),
    .row_ready(a_row_ready), .busy(a_busy), .done(a_done), .total_removed(a_total), .round_count(a_rounds)
`ifdef GRID_ROUND_LIMIT_EN
    , .limit_hit(a_limit)
`endif
  );

  grid_removal_sequencer #(.WIDTH(10), .DEPTH(10), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .start(a_start), .row_valid(a_row_valid), .row_data(a_row_data),
    .row_ready(c_row_ready), .busy(c_busy), .done(c_done), .total_removed(c_total), .round_count(c_rounds)
`ifdef GRID_ROUND_LIMIT_EN
    , .limit_hit(c_limit)
`endif
  );

  grid_removal_sequencer #(.WIDTH(3), .DEPTH(3)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .row_valid(b_row_valid), .row_data(b_row_data),
    .row_ready(b_row_ready), .busy(b_busy), .done(b_done), .total_removed(b_total), .round_count(b_rounds)
`ifdef GRID_ROUND_LIMIT_EN
    , .limit_hit(b_limit)
`endif
  );

`ifdef GRID_ROUND_LIMIT_EN
  grid_removal_sequencer #(.WIDTH(3), .DEPTH(3), .MAX_ROUNDS(1)) u_l (
    .clk(clk), .rst(rst), .start(b_start), .row_valid(b_row_valid), .row_data(b_row_data),
    .row_ready(l_row_ready), .busy(l_busy), .done(l_done), .total_removed(l_total), .round_count(l_rounds),
    .limit_hit(l_limit)
  );
`endif

  // Sweeps in place until a sweep removes nothing (or maxr sweeps, when maxr > 0).
  function automatic void model(input grid_t gi, input int w, input int d, input int maxr,
                                output int total, output int rounds, output grid_t go);
    grid_t g = gi;
    int cnt, nb, rr, cc;
    bit stop = 1'b0;
    total  = 0;
    rounds = 0;
    while (!stop) begin
      rounds++;
      cnt = 0;
      for (int r = 0; r < d; r++)
        for (int c = 0; c < w; c++)
          if (g[r][c]) begin
            nb = 0;
            for (int dr = -1; dr <= 1; dr++)
              for (int dc = -1; dc <= 1; dc++) begin
                rr = r + dr;
                cc = c + dc;
                if ((dr != 0 || dc != 0) && rr >= 0 && rr < d && cc >= 0 && cc < w && g[rr][cc]) nb++;
              end
            if (nb < TH) begin
              g[r][c] = 1'b0;
              cnt++;
            end
          end
      total += cnt;
      if (cnt == 0 || (maxr > 0 && rounds == maxr)) stop = 1'b1;
    end
    go = g;
  endfunction

  function automatic int sat(input int x, input int m);
    return (x > m) ? m : x;
  endfunction

  function automatic grid_t rand_grid(input int w, input int d, input int dens);
    grid_t g = '{default: 1'b0};
    for (int r = 0; r < d; r++)
      for (int c = 0; c < w; c++)
        g[r][c] = ($urandom_range(99) < dens);
    return g;
  endfunction

  task automatic run_a(input grid_t g, input int gap_pct, input bit poke, input string name,
                       output int lat_total, output int got_total, output int got_rounds);
    int exp_total, exp_rounds, t, t_load, row;
    grid_t go;
    bit v, rr;
    logic [9:0] rd;
    model(g, 10, 10, 0, exp_total, exp_rounds, go);
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    t = 0;
    n_checks++;
    if (a_busy !== 1'b1 || a_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s job_started: busy=%b done=%b, required busy=1 done=0", name, a_busy, a_done);
    end
    row = 0;
    while (row < 10 && t < 1000) begin
      v = ($urandom_range(99) >= gap_pct);
      for (int c = 0; c < 10; c++) rd[c] = g[row][c];
      a_row_valid = v;
      a_row_data  = v ? rd : 10'($urandom);
      rr = a_row_ready;
      @(negedge clk);
      t++;
      if (v && rr) row++;
    end
    a_row_valid = 1'b0;
    a_row_data  = 10'($urandom);
    t_load = t;
    while (!a_done && t < t_load + 3000) begin
      a_start = (poke && t == t_load + 20);
      @(negedge clk);
      t++;
    end
    a_start = 1'b0;
    lat_total  = t;
    got_total  = int'(a_total);
    got_rounds = int'(a_rounds);
    n_checks++;
    if (a_done !== 1'b1 || row != 10) begin
      n_fail++;
      $display("FAIL %s completion: done=%b rows=%0d, required done=1 rows=10", name, a_done, row);
    end
    n_checks++;
    if (t - t_load != exp_rounds * 101) begin
      n_fail++;
      $display("FAIL %s sweep_latency: got %0d cycles, required %0d", name, t - t_load, exp_rounds * 101);
    end
    n_checks++;
    if (a_total !== 16'(exp_total)) begin
      n_fail++;
      $display("FAIL %s total_removed: got %0d, required %0d", name, a_total, exp_total);
    end
    n_checks++;
    if (a_rounds !== 16'(exp_rounds)) begin
      n_fail++;
      $display("FAIL %s round_count: got %0d, required %0d", name, a_rounds, exp_rounds);
    end
    n_checks++;
    if (c_done !== 1'b1 || c_total !== 2'(sat(exp_total, 3)) || c_rounds !== 2'(sat(exp_rounds, 3))) begin
      n_fail++;
      $display("FAIL %s saturating: done=%b total=%0d rounds=%0d, required done=1 total=%0d rounds=%0d",
               name, c_done, c_total, c_rounds, sat(exp_total, 3), sat(exp_rounds, 3));
    end
`ifdef GRID_ROUND_LIMIT_EN
    n_checks++;
    if (a_limit !== 1'b0) begin
      n_fail++;
      $display("FAIL %s limit_hit: got %b, required 0", name, a_limit);
    end
`endif
    repeat (3) @(negedge clk);
    n_checks++;
    if (a_done !== 1'b1 || a_total !== 16'(exp_total) || a_rounds !== 16'(exp_rounds) || a_row_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_hold: done=%b total=%0d rounds=%0d ready=%b, required 1/%0d/%0d/0",
               name, a_done, a_total, a_rounds, a_row_ready, exp_total, exp_rounds);
    end
  endtask

  task automatic run_b(input grid_t g, input string name);
    int exp_total, exp_rounds, t, t_load;
    grid_t go;
    logic [2:0] rd;
`ifdef GRID_ROUND_LIMIT_EN
    int l_exp_total, l_exp_rounds;
    grid_t lgo;
    model(g, 3, 3, 1, l_exp_total, l_exp_rounds, lgo);
`endif
    model(g, 3, 3, 0, exp_total, exp_rounds, go);
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    b_row_valid = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) rd[c] = g[r][c];
      b_row_data = rd;
      @(negedge clk);
    end
    b_row_valid = 1'b0;
    t = 0;
    t_load = 0;
    while (!b_done && t < 500) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (b_done !== 1'b1 || t - t_load != exp_rounds * 10) begin
      n_fail++;
      $display("FAIL %s small_latency: done=%b cycles=%0d, required done=1 cycles=%0d", name, b_done, t, exp_rounds * 10);
    end
    n_checks++;
    if (b_total !== 16'(exp_total) || b_rounds !== 16'(exp_rounds)) begin
      n_fail++;
      $display("FAIL %s small_result: total=%0d rounds=%0d, required %0d/%0d", name, b_total, b_rounds, exp_total, exp_rounds);
    end
`ifdef GRID_ROUND_LIMIT_EN
    n_checks++;
    if (l_done !== 1'b1 || l_total !== 16'(l_exp_total) || l_rounds !== 16'(l_exp_rounds) ||
        l_limit !== (l_exp_total != 0)) begin
      n_fail++;
      $display("FAIL %s round_limit: done=%b total=%0d rounds=%0d limit=%b, required 1/%0d/%0d/%b",
               name, l_done, l_total, l_rounds, l_limit, l_exp_total, l_exp_rounds, l_exp_total != 0);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (a_busy !== 1'b0 || a_done !== 1'b0 || a_row_ready !== 1'b0 || a_total !== 16'd0 || a_rounds !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_a: busy=%b done=%b ready=%b total=%0d rounds=%0d, required all 0",
               a_busy, a_done, a_row_ready, a_total, a_rounds);
    end
    n_checks++;
    if (b_busy !== 1'b0 || b_done !== 1'b0 || b_row_ready !== 1'b0 || b_total !== 16'd0 || b_rounds !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_b: busy=%b done=%b ready=%b total=%0d rounds=%0d, required all 0",
               b_busy, b_done, b_row_ready, b_total, b_rounds);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_idle_rows();
    int bad = 0;
    a_row_valid = 1'b1;
    a_row_data  = 10'h3FF;
    repeat (6) begin
      @(negedge clk);
      if (a_row_ready !== 1'b0 || a_busy !== 1'b0) bad++;
    end
    a_row_valid = 1'b0;
    n_checks++;
    if (bad != 0 || u_a.grid !== '0) begin
      n_fail++;
      $display("FAIL idle_rows: bad_cycles=%0d grid_nonzero=%b, required 0/0", bad, u_a.grid !== '0);
    end
  endtask

  task automatic test_empty_grid();
    int lat, tot, rnd;
    run_a('{default: 1'b0}, 0, 1'b0, "empty", lat, tot, rnd);
    n_checks++;
    if (lat != 111 || tot != 0 || rnd != 1) begin
      n_fail++;
      $display("FAIL empty_scenario: latency=%0d total=%0d rounds=%0d, required 111/0/1", lat, tot, rnd);
    end
  endtask

  task automatic test_single_cell();
    int lat, tot, rnd;
    grid_t g = '{default: 1'b0};
    g[5][5] = 1'b1;
    run_a(g, 20, 1'b0, "single", lat, tot, rnd);
    n_checks++;
    if (tot != 1 || rnd != 2) begin
      n_fail++;
      $display("FAIL single_scenario: total=%0d rounds=%0d, required 1/2", tot, rnd);
    end
  endtask

  task automatic test_random();
    int lat, tot, rnd;
    for (int i = 0; i < 6; i++)
      run_a(rand_grid(10, 10, 20 + 12 * i), 30, 1'b0, "random", lat, tot, rnd);
  endtask

  task automatic test_start_ignored();
    int lat, tot, rnd;
    run_a(rand_grid(10, 10, 60), 0, 1'b1, "start_in_scan", lat, tot, rnd);
  endtask

  task automatic test_back_to_back();
    int lat, tot, rnd;
    run_a(rand_grid(10, 10, 70), 0, 1'b0, "b2b_first", lat, tot, rnd);
    run_a(rand_grid(10, 10, 45), 10, 1'b0, "b2b_second", lat, tot, rnd);
  endtask

  task automatic test_rst_mid_scan();
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    a_row_valid = 1'b1;
    a_row_data  = 10'h3FF;
    repeat (10) @(negedge clk);
    a_row_valid = 1'b0;
    repeat (37) @(negedge clk);
    n_checks++;
    if (a_busy !== 1'b1 || a_row_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL scan_state: busy=%b ready=%b, required 1/0", a_busy, a_row_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (a_busy !== 1'b0 || a_done !== 1'b0 || a_row_ready !== 1'b0 || a_total !== 16'd0 ||
        a_rounds !== 16'd0 || u_a.grid !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_scan: busy=%b done=%b ready=%b total=%0d rounds=%0d grid_nonzero=%b, required all 0",
               a_busy, a_done, a_row_ready, a_total, a_rounds, u_a.grid !== '0);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (a_done !== 1'b0 || a_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL no_partial_result: done=%b busy=%b, required 0/0", a_done, a_busy);
    end
  endtask

  task automatic test_small();
    grid_t g = '{default: 1'b0};
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) g[r][c] = 1'b1;
    run_b(g, "small_full");
    n_checks++;
    if (b_total !== 16'd9 || b_rounds !== 16'd3 || u_b.grid !== '0) begin
      n_fail++;
      $display("FAIL small_full_scenario: total=%0d rounds=%0d grid_nonzero=%b, required 9/3/0",
               b_total, b_rounds, u_b.grid !== '0);
    end
`ifdef GRID_ROUND_LIMIT_EN
    n_checks++;
    if (l_limit !== 1'b1 || l_total !== 16'd4 || l_rounds !== 16'd1 || l_done !== 1'b1) begin
      n_fail++;
      $display("FAIL limit_scenario: limit=%b total=%0d rounds=%0d done=%b, required 1/4/1/1",
               l_limit, l_total, l_rounds, l_done);
    end
`endif
    for (int i = 0; i < 4; i++) run_b(rand_grid(3, 3, 40 + 15 * i), "small_random");
  endtask

  initial begin
    rst = 1'b1;
    a_start = 1'b0;
    a_row_valid = 1'b0;
    a_row_data = '0;
    b_start = 1'b0;
    b_row_valid = 1'b0;
    b_row_data = '0;
    test_reset();
    test_idle_rows();
    test_empty_grid();
    test_single_cell();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_rst_mid_scan();
    test_small();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
